// File: rtl/uart_pkg.sv
// ============================================================================
// Module      : uart_pkg
// Description : Shared types and helpers for the uart_fifo_xcvr transceiver.
//               Optional parity support is selected with UART_PARITY_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package uart_pkg;

    // Transmit state machine encoding
    typedef enum logic [2:0] {
        TX_IDLE   = 3'd0,
        TX_START  = 3'd1,
        TX_DATA   = 3'd2,
`ifdef UART_PARITY_EN
        TX_PARITY = 3'd3,
`endif
        TX_STOP   = 3'd4
    } tx_state_t;

    // Receive state machine encoding
    typedef enum logic [2:0] {
        RX_IDLE   = 3'd0,
        RX_START  = 3'd1,
        RX_DATA   = 3'd2,
`ifdef UART_PARITY_EN
        RX_PARITY = 3'd3,
`endif
        RX_STOP   = 3'd4
    } rx_state_t;

    // Bit-period counter width for a given clocks-per-bit value (CNT_W)
    function automatic int cnt_width(input int clks);
        return $clog2(clks);
    endfunction

    // Even-parity bit of up to 8 data bits (unused upper bits must be zero)
    function automatic logic parity_of(input logic [7:0] d);
        return ^d;
    endfunction

endpackage

`default_nettype wire

// File: rtl/uart_sync_fifo.sv
// ============================================================================
// Module      : uart_sync_fifo
// Description : Small synchronous FIFO with show-ahead head output. Pointers
//               carry one extra wrap bit so full and empty are unambiguous.
//               A push while full is accepted if a pop happens in the same cycle.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module uart_sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_head,
    output logic             o_full,
    output logic             o_empty
);

    localparam int AW = $clog2(DEPTH);

    logic [AW:0]      r_wr_ptr;
    logic [AW:0]      r_rd_ptr;
    logic [WIDTH-1:0] r_mem [DEPTH];

    logic w_empty;
    logic w_full;
    logic w_do_pop;
    logic w_do_push;

    assign w_empty   = (r_wr_ptr == r_rd_ptr);
    assign w_full    = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                       (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
    assign w_do_pop  = i_pop & ~w_empty;
    assign w_do_push = i_push & (~w_full | w_do_pop);

    assign o_empty = w_empty;
    assign o_full  = w_full;
    // Head reads as zero when empty so the consumer never sees stale data
    assign o_head  = w_empty ? '0 : r_mem[r_rd_ptr[AW-1:0]];

    // Pointer update and storage write
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else begin
            if (w_do_push) begin
                r_mem[r_wr_ptr[AW-1:0]] <= i_data;
                r_wr_ptr                <= r_wr_ptr + 1'b1;
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/uart_fifo_xcvr.sv
// ============================================================================
// Module      : uart_fifo_xcvr
// Description : Full-duplex UART with configurable frame format and a small
//               valid/ready FIFO on each direction. Define UART_PARITY_EN to
//               add a parity bit (parity_odd selects odd/even).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module uart_fifo_xcvr
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 434,
    parameter int DATA_BITS    = 8,
    parameter int STOP_BITS    = 1,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
`ifdef UART_PARITY_EN
    input  logic                 parity_odd,
`endif
    input  logic                 io_rxd,
    output logic                 io_txd,
    input  logic [DATA_BITS-1:0] tx_data,
    input  logic                 tx_valid,
    output logic                 tx_ready,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    input  logic                 rx_ready,
    output logic                 frame_err,
    output logic                 rx_overrun,
    output logic                 parity_err
);

    localparam int CNT_W = cnt_width(CLKS_PER_BIT);
    localparam int BIT_W = $clog2(DATA_BITS);

    // ------------------------------------------------------------------------
    // FIFOs
    // ------------------------------------------------------------------------
    logic                 w_tx_full;
    logic                 w_tx_empty;
    logic [DATA_BITS-1:0] w_tx_head;
    logic                 w_tx_load;

    logic                 w_rx_full;
    logic                 w_rx_empty;
    logic                 w_rx_push;

    logic [DATA_BITS-1:0] r_rx_shift;

    uart_sync_fifo #(
        .WIDTH (DATA_BITS),
        .DEPTH (FIFO_DEPTH)
    ) u_tx_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_push  (tx_valid & ~w_tx_full),
        .i_data  (tx_data),
        .i_pop   (w_tx_load),
        .o_head  (w_tx_head),
        .o_full  (w_tx_full),
        .o_empty (w_tx_empty)
    );

    uart_sync_fifo #(
        .WIDTH (DATA_BITS),
        .DEPTH (FIFO_DEPTH)
    ) u_rx_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_push  (w_rx_push),
        .i_data  (r_rx_shift),
        .i_pop   (rx_ready),
        .o_head  (rx_data),
        .o_full  (w_rx_full),
        .o_empty (w_rx_empty)
    );

    assign tx_ready = ~w_tx_full;
    assign rx_valid = ~w_rx_empty;

    // ------------------------------------------------------------------------
    // Transmitter
    // ------------------------------------------------------------------------
    tx_state_t            r_tx_state;
    logic [CNT_W-1:0]     r_tx_cnt;
    logic [BIT_W-1:0]     r_tx_bit;
    logic                 r_tx_stop;
    logic [DATA_BITS-1:0] r_tx_shift;
    logic                 r_txd;
`ifdef UART_PARITY_EN
    logic                 r_tx_par;
`endif

    logic w_tx_cnt_last;
    logic w_tx_stop_last;

    assign w_tx_cnt_last  = (r_tx_cnt == CNT_W'(CLKS_PER_BIT - 1));
    assign w_tx_stop_last = (r_tx_state == TX_STOP) && w_tx_cnt_last &&
                            ((STOP_BITS == 1) || r_tx_stop);
    // Load a new frame from idle, or straight out of the final stop bit
    assign w_tx_load      = ~w_tx_empty && ((r_tx_state == TX_IDLE) || w_tx_stop_last);
    assign io_txd         = r_txd;

    // TX frame sequencer; the load at the bottom overrides the case result
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_tx_state <= TX_IDLE;
            r_tx_cnt   <= '0;
            r_tx_bit   <= '0;
            r_tx_stop  <= 1'b0;
            r_tx_shift <= '0;
            r_txd      <= 1'b1;
`ifdef UART_PARITY_EN
            r_tx_par   <= 1'b0;
`endif
        end else begin
            r_tx_cnt <= w_tx_cnt_last ? '0 : r_tx_cnt + 1'b1;
            case (r_tx_state)
                TX_IDLE: begin
                    r_tx_cnt <= '0;
                end
                TX_START: begin
                    if (w_tx_cnt_last) begin
                        r_tx_state <= TX_DATA;
                        r_tx_bit   <= '0;
                        r_txd      <= r_tx_shift[0];
                    end
                end
                TX_DATA: begin
                    if (w_tx_cnt_last) begin
                        if (r_tx_bit == BIT_W'(DATA_BITS - 1)) begin
`ifdef UART_PARITY_EN
                            r_tx_state <= TX_PARITY;
                            r_txd      <= r_tx_par;
`else
                            r_tx_state <= TX_STOP;
                            r_tx_stop  <= 1'b0;
                            r_txd      <= 1'b1;
`endif
                        end else begin
                            r_tx_bit   <= r_tx_bit + 1'b1;
                            r_tx_shift <= r_tx_shift >> 1;
                            r_txd      <= r_tx_shift[1];
                        end
                    end
                end
`ifdef UART_PARITY_EN
                TX_PARITY: begin
                    if (w_tx_cnt_last) begin
                        r_tx_state <= TX_STOP;
                        r_tx_stop  <= 1'b0;
                        r_txd      <= 1'b1;
                    end
                end
`endif
                TX_STOP: begin
                    if (w_tx_stop_last) begin
                        r_tx_state <= TX_IDLE;
                    end else if (w_tx_cnt_last) begin
                        r_tx_stop <= 1'b1;
                    end
                end
                default: begin
                    r_tx_state <= TX_IDLE;
                    r_txd      <= 1'b1;
                end
            endcase
            if (w_tx_load) begin
                r_tx_state <= TX_START;
                r_tx_cnt   <= '0;
                r_tx_shift <= w_tx_head;
                r_txd      <= 1'b0;
`ifdef UART_PARITY_EN
                r_tx_par   <= parity_of(8'(w_tx_head)) ^ parity_odd;
`endif
            end
        end
    end

    // ------------------------------------------------------------------------
    // Receiver
    // ------------------------------------------------------------------------
    logic r_sync1;
    logic r_sync2;
    logic r_sync3;

    // Two-flop synchroniser plus one delayed copy for edge detection
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync1 <= 1'b1;
            r_sync2 <= 1'b1;
            r_sync3 <= 1'b1;
        end else begin
            r_sync1 <= io_rxd;
            r_sync2 <= r_sync1;
            r_sync3 <= r_sync2;
        end
    end

    rx_state_t        r_rx_state;
    logic [CNT_W-1:0] r_rx_cnt;
    logic [BIT_W-1:0] r_rx_bit;
`ifdef UART_PARITY_EN
    logic             r_rx_par_bit;
    logic             r_rx_odd;
`endif

    logic w_rx_cnt_last;
    logic w_rx_half;
    logic w_rx_stop_eval;
    logic w_rx_par_ok;

    assign w_rx_cnt_last  = (r_rx_cnt == CNT_W'(CLKS_PER_BIT - 1));
    assign w_rx_half      = (r_rx_cnt == CNT_W'(CLKS_PER_BIT / 2 - 1));
    assign w_rx_stop_eval = (r_rx_state == RX_STOP) && w_rx_cnt_last;
`ifdef UART_PARITY_EN
    assign w_rx_par_ok    = (r_rx_par_bit == (parity_of(8'(r_rx_shift)) ^ r_rx_odd));
`else
    assign w_rx_par_ok    = 1'b1;
`endif
    assign w_rx_push      = w_rx_stop_eval && r_sync2 && w_rx_par_ok;

    // RX frame sequencer: samples each bit at its mid-point
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rx_state   <= RX_IDLE;
            r_rx_cnt     <= '0;
            r_rx_bit     <= '0;
            r_rx_shift   <= '0;
`ifdef UART_PARITY_EN
            r_rx_par_bit <= 1'b0;
            r_rx_odd     <= 1'b0;
`endif
        end else begin
            r_rx_cnt <= w_rx_cnt_last ? '0 : r_rx_cnt + 1'b1;
            case (r_rx_state)
                RX_IDLE: begin
                    r_rx_cnt <= '0;
                    if (r_sync3 && !r_sync2) begin
                        r_rx_state <= RX_START;
`ifdef UART_PARITY_EN
                        r_rx_odd   <= parity_odd;
`endif
                    end
                end
                RX_START: begin
                    if (w_rx_half) begin
                        r_rx_cnt <= '0;
                        r_rx_bit <= '0;
                        // A high line at mid-start is a glitch: drop silently
                        r_rx_state <= r_sync2 ? RX_IDLE : RX_DATA;
                    end
                end
                RX_DATA: begin
                    if (w_rx_cnt_last) begin
                        r_rx_shift <= {r_sync2, r_rx_shift[DATA_BITS-1:1]};
                        if (r_rx_bit == BIT_W'(DATA_BITS - 1)) begin
`ifdef UART_PARITY_EN
                            r_rx_state <= RX_PARITY;
`else
                            r_rx_state <= RX_STOP;
`endif
                        end else begin
                            r_rx_bit <= r_rx_bit + 1'b1;
                        end
                    end
                end
`ifdef UART_PARITY_EN
                RX_PARITY: begin
                    if (w_rx_cnt_last) begin
                        r_rx_par_bit <= r_sync2;
                        r_rx_state   <= RX_STOP;
                    end
                end
`endif
                RX_STOP: begin
                    if (w_rx_cnt_last) begin
                        r_rx_state <= RX_IDLE;
                    end
                end
                default: begin
                    r_rx_state <= RX_IDLE;
                end
            endcase
        end
    end

    logic r_frame_err;
    logic r_overrun;
    logic r_par_err;

    // Error pulses; a bad stop bit masks a parity error in the same frame
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_frame_err <= 1'b0;
            r_overrun   <= 1'b0;
            r_par_err   <= 1'b0;
        end else begin
            r_frame_err <= w_rx_stop_eval && !r_sync2;
            r_par_err   <= w_rx_stop_eval && r_sync2 && !w_rx_par_ok;
            r_overrun   <= w_rx_push && w_rx_full && !(rx_ready && !w_rx_empty);
        end
    end

    assign frame_err  = r_frame_err;
    assign rx_overrun = r_overrun;
`ifdef UART_PARITY_EN
    assign parity_err = r_par_err;
`else
    assign parity_err = 1'b0;
`endif

endmodule

`default_nettype wire
